// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave that emulates a PmodJSTK joystick. It serves a 40-bit
// {X, Y, buttons} frame on MISO and captures the master's LED command byte.
module jstk_spi_responder #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FRAME_BITS  = 40
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] x_pos,
   input  logic [9:0] y_pos,
   input  logic [2:0] buttons,
   input  logic       SS,
   input  logic       SCK,
   input  logic       MOSI,
   output logic       MISO,
   output logic [1:0] led,
   output logic       frame_done,
   output logic       frame_err
);

   localparam int unsigned CntW = $clog2(FRAME_BITS + 1);

   typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

   logic [SYNC_STAGES-1:0] ss_sync_q, sck_sync_q, mosi_sync_q;
   logic                   ss_prev_q, sck_prev_q;
   logic                   ss_s, sck_s, mosi_s;
   logic                   ss_fall, ss_rise, sck_rise, sck_fall;

   state_e                 state_q, state_d;
   logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0]  tx_sr_q, tx_sr_d;
   logic [FRAME_BITS-1:0]  rx_sr_q, rx_sr_d;
   logic                   miso_q, miso_d;
   logic [1:0]             led_q, led_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic [FRAME_BITS-1:0]  frame_word;

   // Bytes: x low, x high, y low, y high, buttons.
   assign frame_word = {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8],
                        5'b0, buttons};

   // Pin synchronizers plus one extra flop per line for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_sync_q   <= '1;
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         ss_prev_q   <= 1'b1;
         sck_prev_q  <= 1'b0;
      end else begin
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
         ss_prev_q   <= ss_s;
         sck_prev_q  <= sck_s;
      end
   end

   assign ss_s     = ss_sync_q[SYNC_STAGES-1];
   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign ss_fall  = ss_prev_q & ~ss_s;
   assign ss_rise  = ~ss_prev_q & ss_s;
   assign sck_rise = ~sck_prev_q & sck_s;
   assign sck_fall = sck_prev_q & ~sck_s;

   // Frame state register and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         bit_cnt_q <= '0;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         miso_q    <= 1'b0;
         led_q     <= 2'b00;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         miso_q    <= miso_d;
         led_q     <= led_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Next-state logic; SS events take priority over SCK edges.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      miso_d    = miso_q;
      led_d     = led_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         StIdle: begin
            miso_d = 1'b0;
            if (ss_fall) begin
               tx_sr_d   = frame_word;
               miso_d    = frame_word[FRAME_BITS-1];
               bit_cnt_d = '0;
               state_d   = StShift;
            end
         end
         StShift: begin
            if (ss_rise) begin
               // A window with no clocks at all is not treated as an error.
               err_d   = (bit_cnt_q != '0);
               miso_d  = 1'b0;
               state_d = StIdle;
            end else if (sck_rise) begin
               rx_sr_d   = {rx_sr_q[FRAME_BITS-2:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == CntW'(FRAME_BITS - 1)) begin
                  miso_d  = 1'b0;
                  state_d = StHold;
               end
            end else if (sck_fall) begin
               tx_sr_d = {tx_sr_q[FRAME_BITS-2:0], 1'b0};
               miso_d  = tx_sr_q[FRAME_BITS-2];
            end
         end
         StHold: begin
            miso_d = 1'b0;
            if (ss_rise) begin
               // Command byte 0 now sits at the top of rx_sr; keep its low 2 bits.
               led_d   = rx_sr_q[FRAME_BITS-7:FRAME_BITS-8];
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: begin
            miso_d  = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   assign MISO       = miso_q;
   assign led        = led_q;
   assign frame_done = done_q;
   assign frame_err  = err_q;

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Bench for jstk_spi_responder: drives SPI frames as a mode-0 master and
// checks MISO, led and the done/err pulses against a frame-level model.
module tb_jstk_spi_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] x_pos, y_pos;
   logic [2:0] buttons;
   logic       SS, SCK, MOSI;
   logic       MISO;
   logic [1:0] led;
   logic       frame_done, frame_err;

   int         vectors     = 0;
   int         miscompares = 0;
   logic [1:0] model_led;
   bit         settle;
   int         done_seen   = 0;
   int         err_seen    = 0;
   int         ss_high_cnt = 0;
   logic [9:0] x_next, y_next;
   logic [2:0] b_next;
   logic [63:0] rx;

   jstk_spi_responder #(.SYNC_STAGES(2), .FRAME_BITS(40)) dut (
      .clk(clk), .rst(rst), .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons),
      .SS(SS), .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .led(led),
      .frame_done(frame_done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   function automatic logic [39:0] frame_of(input logic [9:0] x, input logic [9:0] y,
                                            input logic [2:0] b);
      return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, b};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Per-cycle compare: reset values, led against the model, idle MISO, pulse exclusivity.
   always @(negedge clk) begin
      ss_high_cnt <= SS ? ss_high_cnt + 1 : 0;
      if (rst) begin
         check("rst_miso", MISO, 0);
         check("rst_led", led, 0);
         check("rst_done", frame_done, 0);
         check("rst_err", frame_err, 0);
      end else begin
         check("done_err_excl", frame_done & frame_err, 0);
         if (!settle) check("led", led, model_led);
         if (SS && ss_high_cnt >= 5) check("miso_idle", MISO, 0);
         if (frame_done) done_seen++;
         if (frame_err) err_seen++;
      end
   end

   // One SS window of nbits SCK cycles. Inputs switch to *_next at bit chg_at;
   // reset is pulsed at bit rst_at (negative values disable either).
   task automatic spi_frame(input int nbits, input logic [7:0] cmd, input int chg_at,
                            input int rst_at, output logic [63:0] rxw);
      logic [39:0] snap;
      int          d0, e0;
      bit          reset_hit;
      d0 = done_seen;
      e0 = err_seen;
      reset_hit = 1'b0;
      rxw = '0;
      snap = frame_of(x_pos, y_pos, buttons);
      SS = 1'b0;
      tick(8);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst = 1'b1;
            model_led = 2'b00;
            SCK = 1'b0;
            tick(3);
            SS = 1'b1;
            tick(3);
            rst = 1'b0;
            tick(10);
            reset_hit = 1'b1;
            break;
         end
         MOSI = (i < 8) ? cmd[7-i] : 1'($urandom);
         tick(6);
         rxw = {rxw[62:0], MISO};
         check("miso_bit", MISO, (i < 40) ? snap[39-i] : 1'b0);
         SCK = 1'b1;
         if (i == chg_at) begin
            x_pos = x_next;
            y_pos = y_next;
            buttons = b_next;
         end
         tick(6);
         SCK = 1'b0;
      end
      if (!reset_hit) begin
         tick(6);
         SS = 1'b1;
         settle = 1'b1;
         tick(12);
         if (nbits >= 40) model_led = cmd[1:0];
         settle = 1'b0;
      end
      check("done_count", done_seen - d0, (!reset_hit && nbits >= 40) ? 1 : 0);
      check("err_count", err_seen - e0, (!reset_hit && nbits > 0 && nbits < 40) ? 1 : 0);
   endtask

   initial begin
      rst = 1'b1;
      SS = 1'b1;
      SCK = 1'b0;
      MOSI = 1'b0;
      x_pos = '0;
      y_pos = '0;
      buttons = '0;
      x_next = '0;
      y_next = '0;
      b_next = '0;
      model_led = 2'b00;
      settle = 1'b0;
      tick(4);
      rst = 1'b0;
      tick(4);
      check("reset_led", led, 2'b00);
      check("reset_miso", MISO, 1'b0);

      // Worked example from the datasheet, pinning the model as well.
      x_pos = 10'h2A5; y_pos = 10'h15A; buttons = 3'b101;
      check("model_t1", frame_of(x_pos, y_pos, buttons), 40'hA5025A0105);
      spi_frame(40, 8'h83, -1, -1, rx);
      check("t1_bytes", rx[39:0], 40'hA5025A0105);
      check("t1_led", led, 2'b11);

      // Centre X, zero Y, no buttons.
      x_pos = 10'd512; y_pos = 10'd0; buttons = 3'b000;
      spi_frame(40, 8'hFF, -1, -1, rx);
      check("t2_bytes", rx[39:0], 40'h0002000000);

      // Abort after 17 bits leaves led alone; next full frame is clean.
      x_pos = 10'h2A5; y_pos = 10'h15A; buttons = 3'b101;
      spi_frame(17, 8'h02, -1, -1, rx);
      check("t3_led_kept", led, 2'b11);
      spi_frame(40, 8'h42, -1, -1, rx);
      check("t3_bytes", rx[39:0], 40'hA5025A0105);
      check("t3_led", led, 2'b10);

      // 48 clocks in one window: trailing bits are zero, led from byte 0.
      spi_frame(48, 8'h01, -1, -1, rx);
      check("t4_head", rx[47:8], 40'hA5025A0105);
      check("t4_tail", rx[7:0], 8'h00);
      check("t4_led", led, 2'b01);

      // Mid-frame input change does not disturb the frame in flight.
      x_pos = 10'h000; y_pos = 10'h000; buttons = 3'b000;
      x_next = 10'h3FF; y_next = 10'h000; b_next = 3'b000;
      spi_frame(40, 8'h00, 10, -1, rx);
      check("t5_old", rx[39:0], 40'h0);
      spi_frame(40, 8'h03, -1, -1, rx);
      check("t5_new", rx[39:0], 40'hFF03000000);

      // Reset mid-frame, then a full frame.
      spi_frame(40, 8'h01, -1, 20, rx);
      check("t6_led_rst", led, 2'b00);
      x_pos = 10'h2A5; y_pos = 10'h15A; buttons = 3'b101;
      spi_frame(40, 8'h83, -1, -1, rx);
      check("t6_bytes", rx[39:0], 40'hA5025A0105);
      check("t6_led", led, 2'b11);

      // Randomized frames: random data, lengths and mid-frame input churn.
      for (int n = 0; n < 20; n++) begin
         int          r, nb;
         logic [7:0]  cmd;
         x_pos = 10'($urandom); y_pos = 10'($urandom); buttons = 3'($urandom);
         x_next = 10'($urandom); y_next = 10'($urandom); b_next = 3'($urandom);
         cmd = 8'($urandom);
         r = int'($urandom_range(0, 5));
         case (r)
            0:       nb = 0;
            1:       nb = int'($urandom_range(1, 39));
            2:       nb = 48;
            default: nb = 40;
         endcase
         spi_frame(nb, cmd, int'($urandom_range(0, 45)), -1, rx);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
